// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcode values, FSM state
// encoding and bit positions of the control-strobe vector.
package cpu_pkg;

    localparam logic [4:0] OP_LD        = 5'd0;
    localparam logic [4:0] OP_LDI       = 5'd1;
    localparam logic [4:0] OP_ST        = 5'd2;
    localparam logic [4:0] OP_ALU_FIRST = 5'd3;
    localparam logic [4:0] OP_ALU_LAST  = 5'd11;
    localparam logic [4:0] OP_IMM_FIRST = 5'd12;
    localparam logic [4:0] OP_IMM_LAST  = 5'd14;
    localparam logic [4:0] OP_MUL       = 5'd15;
    localparam logic [4:0] OP_DIV       = 5'd16;
    localparam logic [4:0] OP_NEG       = 5'd17;
    localparam logic [4:0] OP_NOT       = 5'd18;
    localparam logic [4:0] OP_BR        = 5'd19;
    localparam logic [4:0] OP_JR        = 5'd20;
    localparam logic [4:0] OP_JAL       = 5'd21;
    localparam logic [4:0] OP_IN        = 5'd22;
    localparam logic [4:0] OP_OUT       = 5'd23;
    localparam logic [4:0] OP_MFHI      = 5'd24;
    localparam logic [4:0] OP_MFLO      = 5'd25;
    localparam logic [4:0] OP_NOP       = 5'd26;
    localparam logic [4:0] OP_HALT      = 5'd27;

    localparam int STATE_W = 6;

    // Every instruction owns its execute states so outputs stay a pure
    // function of the state; only br splits at T6 on con_ff.
    typedef enum logic [STATE_W-1:0] {
        S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_HALT,
        S_LDI_T3, S_LDI_T4, S_LDI_T5,
        S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
        S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
        S_ALU_T3, S_ALU_T4, S_ALU_T5,
        S_IMM_T3, S_IMM_T4, S_IMM_T5,
        S_MD_T3, S_MD_T4, S_MD_T5, S_MD_T6,
        S_NN_T3, S_NN_T4,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6_TAKEN, S_BR_T6_IDLE,
        S_JR_T3, S_JAL_T3, S_JAL_T4,
        S_IN_T3, S_OUT_T3, S_MFHI_T3, S_MFLO_T3, S_NOP_T3
    } state_t;

    localparam int CTL_W = 28;

    localparam int C_PCOUT   = 0;
    localparam int C_MDROUT  = 1;
    localparam int C_ZHOUT   = 2;
    localparam int C_ZLOUT   = 3;
    localparam int C_HIOUT   = 4;
    localparam int C_LOOUT   = 5;
    localparam int C_INPOUT  = 6;
    localparam int C_COUT    = 7;
    localparam int C_BAOUT   = 8;
    localparam int C_MARIN   = 9;
    localparam int C_MDRIN   = 10;
    localparam int C_PCIN    = 11;
    localparam int C_IRIN    = 12;
    localparam int C_YIN     = 13;
    localparam int C_ZHIN    = 14;
    localparam int C_ZLIN    = 15;
    localparam int C_HIIN    = 16;
    localparam int C_LOIN    = 17;
    localparam int C_CONIN   = 18;
    localparam int C_OUTPIN  = 19;
    localparam int C_INCPC   = 20;
    localparam int C_READ    = 21;
    localparam int C_WRITE   = 22;
    localparam int C_GRA     = 23;
    localparam int C_GRB     = 24;
    localparam int C_GRC     = 25;
    localparam int C_RIN     = 26;
    localparam int C_ROUT    = 27;

endpackage

// File: rtl/control_decode.sv
// Pure state-to-strobe mapping for the control unit; no storage.
module control_decode
    import cpu_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    output logic [CTL_W-1:0]   ctl,
    output logic               run
);

    state_t st;
    assign st = state_t'(state);

    always_comb begin
        ctl = '0;
        run = 1'b1;
        case (st)
            S_RESET, S_HALT: run = 1'b0;
            S_FETCH0: begin ctl[C_PCOUT] = 1'b1; ctl[C_MARIN] = 1'b1; ctl[C_INCPC] = 1'b1; ctl[C_ZLIN] = 1'b1; end
            S_FETCH1: begin ctl[C_ZLOUT] = 1'b1; ctl[C_PCIN] = 1'b1; ctl[C_READ] = 1'b1; ctl[C_MDRIN] = 1'b1; end
            S_FETCH2: begin ctl[C_MDROUT] = 1'b1; ctl[C_IRIN] = 1'b1; end
            // ld, ldi and st share the effective-address computation
            S_LDI_T3, S_LD_T3, S_ST_T3: begin ctl[C_GRB] = 1'b1; ctl[C_BAOUT] = 1'b1; ctl[C_YIN] = 1'b1; end
            S_LDI_T4, S_LD_T4, S_ST_T4: begin ctl[C_COUT] = 1'b1; ctl[C_ZLIN] = 1'b1; end
            S_LD_T5, S_ST_T5: begin ctl[C_ZLOUT] = 1'b1; ctl[C_MARIN] = 1'b1; end
            S_LD_T6: begin ctl[C_READ] = 1'b1; ctl[C_MDRIN] = 1'b1; end
            S_LD_T7: begin ctl[C_MDROUT] = 1'b1; ctl[C_GRA] = 1'b1; ctl[C_RIN] = 1'b1; end
            S_ST_T6: begin ctl[C_GRA] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_MDRIN] = 1'b1; end
            S_ST_T7: ctl[C_WRITE] = 1'b1;
            S_ALU_T3, S_IMM_T3: begin ctl[C_GRB] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_YIN] = 1'b1; end
            S_ALU_T4: begin ctl[C_GRC] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_ZLIN] = 1'b1; end
            S_IMM_T4, S_BR_T5: begin ctl[C_COUT] = 1'b1; ctl[C_ZLIN] = 1'b1; end
            S_LDI_T5, S_ALU_T5, S_IMM_T5, S_NN_T4: begin ctl[C_ZLOUT] = 1'b1; ctl[C_GRA] = 1'b1; ctl[C_RIN] = 1'b1; end
            S_MD_T3: begin ctl[C_GRA] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_YIN] = 1'b1; end
            S_MD_T4: begin ctl[C_GRB] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_ZHIN] = 1'b1; ctl[C_ZLIN] = 1'b1; end
            S_MD_T5: begin ctl[C_ZLOUT] = 1'b1; ctl[C_LOIN] = 1'b1; end
            S_MD_T6: begin ctl[C_ZHOUT] = 1'b1; ctl[C_HIIN] = 1'b1; end
            S_NN_T3: begin ctl[C_GRB] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_ZLIN] = 1'b1; end
            S_BR_T3: begin ctl[C_GRA] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_CONIN] = 1'b1; end
            S_BR_T4: begin ctl[C_PCOUT] = 1'b1; ctl[C_YIN] = 1'b1; end
            S_BR_T6_TAKEN: begin ctl[C_ZLOUT] = 1'b1; ctl[C_PCIN] = 1'b1; end
            S_JR_T3, S_JAL_T4: begin ctl[C_GRA] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_PCIN] = 1'b1; end
            S_JAL_T3: begin ctl[C_PCOUT] = 1'b1; ctl[C_GRB] = 1'b1; ctl[C_RIN] = 1'b1; end
            S_IN_T3: begin ctl[C_INPOUT] = 1'b1; ctl[C_GRA] = 1'b1; ctl[C_RIN] = 1'b1; end
            S_OUT_T3: begin ctl[C_GRA] = 1'b1; ctl[C_ROUT] = 1'b1; ctl[C_OUTPIN] = 1'b1; end
            S_MFHI_T3: begin ctl[C_HIOUT] = 1'b1; ctl[C_GRA] = 1'b1; ctl[C_RIN] = 1'b1; end
            S_MFLO_T3: begin ctl[C_LOOUT] = 1'b1; ctl[C_GRA] = 1'b1; ctl[C_RIN] = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM for the CPU: fetch, opcode dispatch and per-instruction
// execute sequences, with strobes decoded from the state by control_decode.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        run,
    output logic        PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout,
    output logic        MARin, MDRin, PCin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin, CONin, OutPortin,
    output logic        IncPC, Read, Write,
    output logic        Gra, Grb, Grc, Rin, Rout
);

    state_t           state_q, state_d;
    logic [4:0]       opcode;
    logic [CTL_W-1:0] ctl;
    logic             ir_unused;

    assign opcode    = ir[31:27];
    assign ir_unused = ^ir[26:0];

    always_ff @(posedge clk) begin
        if (clr) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH0;
        case (state_q)
            S_RESET:  state_d = S_FETCH0;
            S_FETCH0: state_d = stop ? S_HALT : S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                case (opcode) inside
                    OP_LD:                       state_d = S_LD_T3;
                    OP_LDI:                      state_d = S_LDI_T3;
                    OP_ST:                       state_d = S_ST_T3;
                    [OP_ALU_FIRST:OP_ALU_LAST]:  state_d = S_ALU_T3;
                    [OP_IMM_FIRST:OP_IMM_LAST]:  state_d = S_IMM_T3;
                    OP_MUL, OP_DIV:              state_d = S_MD_T3;
                    OP_NEG, OP_NOT:              state_d = S_NN_T3;
                    OP_BR:                       state_d = S_BR_T3;
                    OP_JR:                       state_d = S_JR_T3;
                    OP_JAL:                      state_d = S_JAL_T3;
                    OP_IN:                       state_d = S_IN_T3;
                    OP_OUT:                      state_d = S_OUT_T3;
                    OP_MFHI:                     state_d = S_MFHI_T3;
                    OP_MFLO:                     state_d = S_MFLO_T3;
                    OP_HALT:                     state_d = S_HALT;
                    default:                     state_d = S_NOP_T3;
                endcase
            end
            S_LDI_T3: state_d = S_LDI_T4;
            S_LDI_T4: state_d = S_LDI_T5;
            S_LD_T3:  state_d = S_LD_T4;
            S_LD_T4:  state_d = S_LD_T5;
            S_LD_T5:  state_d = S_LD_T6;
            S_LD_T6:  state_d = S_LD_T7;
            S_ST_T3:  state_d = S_ST_T4;
            S_ST_T4:  state_d = S_ST_T5;
            S_ST_T5:  state_d = S_ST_T6;
            S_ST_T6:  state_d = S_ST_T7;
            S_ALU_T3: state_d = S_ALU_T4;
            S_ALU_T4: state_d = S_ALU_T5;
            S_IMM_T3: state_d = S_IMM_T4;
            S_IMM_T4: state_d = S_IMM_T5;
            S_MD_T3:  state_d = S_MD_T4;
            S_MD_T4:  state_d = S_MD_T5;
            S_MD_T5:  state_d = S_MD_T6;
            S_NN_T3:  state_d = S_NN_T4;
            S_BR_T3:  state_d = S_BR_T4;
            S_BR_T4:  state_d = S_BR_T5;
            // con_ff has settled by T5, so the branch decision is taken here
            S_BR_T5:  state_d = con_ff ? S_BR_T6_TAKEN : S_BR_T6_IDLE;
            S_JAL_T3: state_d = S_JAL_T4;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH0;
        endcase
    end

    control_decode u_decode (
        .state (state_q),
        .ctl   (ctl),
        .run   (run)
    );

    assign PCout     = ctl[C_PCOUT];
    assign MDRout    = ctl[C_MDROUT];
    assign ZHighout  = ctl[C_ZHOUT];
    assign ZLowout   = ctl[C_ZLOUT];
    assign HIout     = ctl[C_HIOUT];
    assign LOout     = ctl[C_LOOUT];
    assign InPortout = ctl[C_INPOUT];
    assign Cout      = ctl[C_COUT];
    assign BAout     = ctl[C_BAOUT];
    assign MARin     = ctl[C_MARIN];
    assign MDRin     = ctl[C_MDRIN];
    assign PCin      = ctl[C_PCIN];
    assign IRin      = ctl[C_IRIN];
    assign Yin       = ctl[C_YIN];
    assign ZHighIn   = ctl[C_ZHIN];
    assign ZLowIn    = ctl[C_ZLIN];
    assign HIin      = ctl[C_HIIN];
    assign LOin      = ctl[C_LOIN];
    assign CONin     = ctl[C_CONIN];
    assign OutPortin = ctl[C_OUTPIN];
    assign IncPC     = ctl[C_INCPC];
    assign Read      = ctl[C_READ];
    assign Write     = ctl[C_WRITE];
    assign Gra       = ctl[C_GRA];
    assign Grb       = ctl[C_GRB];
    assign Grc       = ctl[C_GRC];
    assign Rin       = ctl[C_RIN];
    assign Rout      = ctl[C_ROUT];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle strobe sequences compared
// against a table of instruction micro-steps built from the instruction set rules.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr, con_ff, stop;
    logic [31:0] ir;
    logic        run;
    logic        PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout;
    logic        MARin, MDRin, PCin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin, CONin, OutPortin;
    logic        IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
        .PCout(PCout), .MDRout(MDRout), .ZHighout(ZHighout), .ZLowout(ZLowout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
        .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .HIin(HIin), .LOin(LOin), .CONin(CONin),
        .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout)
    );

    localparam int PCOUT = 0, MDROUT = 1, ZHOUT = 2, ZLOUT = 3, HIOUT = 4, LOOUT = 5;
    localparam int INPOUT = 6, COUT = 7, BAOUT = 8, MARIN = 9, MDRIN = 10, PCIN = 11;
    localparam int IRIN = 12, YIN = 13, ZHIN = 14, ZLIN = 15, HIIN = 16, LOIN = 17;
    localparam int CONIN = 18, OUTPIN = 19, INCPC = 20, READ = 21, WRITE = 22;
    localparam int GRA = 23, GRB = 24, GRC = 25, RIN = 26, ROUT = 27, RUN = 28;
    localparam logic [28:0] BUSM = 29'h1FF;

    logic [28:0] obs;
    assign obs = {run, Rout, Rin, Grc, Grb, Gra, Write, Read, IncPC, OutPortin, CONin,
                  LOin, HIin, ZLowIn, ZHighIn, Yin, IRin, PCin, MDRin, MARin, BAout,
                  Cout, InPortout, LOout, HIout, ZLowout, ZHighout, MDRout, PCout};

    int tests = 0;
    int fails = 0;
    logic [28:0] exp_q[$];

    function automatic logic [28:0] b(input int i);
        return 29'd1 << i;
    endfunction

    function automatic logic [28:0] f0();
        return b(RUN) | b(PCOUT) | b(MARIN) | b(INCPC) | b(ZLIN);
    endfunction
    function automatic logic [28:0] f1();
        return b(RUN) | b(ZLOUT) | b(PCIN) | b(READ) | b(MDRIN);
    endfunction
    function automatic logic [28:0] f2();
        return b(RUN) | b(MDROUT) | b(IRIN);
    endfunction

    // Expected strobes for T3 onward, one entry per cycle
    task automatic build_exec(input int op, input bit c);
        logic [28:0] ea3, ea4;
        ea3 = b(GRB) | b(BAOUT) | b(YIN);
        ea4 = b(COUT) | b(ZLIN);
        exp_q.delete();
        if (op == 0) begin
            exp_q = '{ea3, ea4, b(ZLOUT) | b(MARIN), b(READ) | b(MDRIN), b(MDROUT) | b(GRA) | b(RIN)};
        end else if (op == 1) begin
            exp_q = '{ea3, ea4, b(ZLOUT) | b(GRA) | b(RIN)};
        end else if (op == 2) begin
            exp_q = '{ea3, ea4, b(ZLOUT) | b(MARIN), b(GRA) | b(ROUT) | b(MDRIN), b(WRITE)};
        end else if (op >= 3 && op <= 11) begin
            exp_q = '{b(GRB) | b(ROUT) | b(YIN), b(GRC) | b(ROUT) | b(ZLIN), b(ZLOUT) | b(GRA) | b(RIN)};
        end else if (op >= 12 && op <= 14) begin
            exp_q = '{b(GRB) | b(ROUT) | b(YIN), b(COUT) | b(ZLIN), b(ZLOUT) | b(GRA) | b(RIN)};
        end else if (op == 15 || op == 16) begin
            exp_q = '{b(GRA) | b(ROUT) | b(YIN), b(GRB) | b(ROUT) | b(ZHIN) | b(ZLIN),
                      b(ZLOUT) | b(LOIN), b(ZHOUT) | b(HIIN)};
        end else if (op == 17 || op == 18) begin
            exp_q = '{b(GRB) | b(ROUT) | b(ZLIN), b(ZLOUT) | b(GRA) | b(RIN)};
        end else if (op == 19) begin
            exp_q = '{b(GRA) | b(ROUT) | b(CONIN), b(PCOUT) | b(YIN), b(COUT) | b(ZLIN),
                      c ? (b(ZLOUT) | b(PCIN)) : 29'd0};
        end else if (op == 20) begin
            exp_q = '{b(GRA) | b(ROUT) | b(PCIN)};
        end else if (op == 21) begin
            exp_q = '{b(PCOUT) | b(GRB) | b(RIN), b(GRA) | b(ROUT) | b(PCIN)};
        end else if (op == 22) exp_q = '{b(INPOUT) | b(GRA) | b(RIN)};
        else if (op == 23)     exp_q = '{b(GRA) | b(ROUT) | b(OUTPIN)};
        else if (op == 24)     exp_q = '{b(HIOUT) | b(GRA) | b(RIN)};
        else if (op == 25)     exp_q = '{b(LOOUT) | b(GRA) | b(RIN)};
        else                   exp_q = '{29'd0};
        foreach (exp_q[i]) exp_q[i] = exp_q[i] | b(RUN);
    endtask

    task automatic check(input string tag, input logic [28:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        tests++;
        assert ($countones(obs & BUSM) <= 1) else begin
            fails++;
            $error("FAIL %s_bus: observed sources %h expected at most one", tag, obs & BUSM);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [4:0] op);
        logic [31:0] rnd;
        rnd = $urandom();
        ir  = {op, rnd[26:0]};
    endtask

    // Starts with the DUT in FETCH0 and leaves it in the next FETCH0
    task automatic do_instr(input string tag, input int op, input bit c);
        con_ff = c;
        stop   = 1'b0;
        check({tag, "_f0"}, f0()); step();
        check({tag, "_f1"}, f1()); step();
        check({tag, "_f2"}, f2()); step();
        build_exec(op, c);
        foreach (exp_q[i]) begin
            check($sformatf("%s_t%0d", tag, i + 3), exp_q[i]);
            step();
        end
    endtask

    task automatic reset_pulse(input string tag);
        clr = 1'b1; step();
        check({tag, "_rst"}, 29'd0);
        clr = 1'b0; step();
        check({tag, "_f0"}, f0());
    endtask

    task automatic hold_halt(input string tag);
        for (int k = 0; k < 20; k++) begin
            check(tag, 29'd0);
            step();
        end
        reset_pulse({tag, "_exit"});
    endtask

    initial begin
        clr = 1'b1; ir = 32'd0; con_ff = 1'b0; stop = 1'b0;
        step();
        check("reset0", 29'd0);
        step();
        check("reset1", 29'd0);
        clr = 1'b0;
        step();

        ir = 32'h0880_0007; do_instr("ldi_r1_7", 1, 1'b0);
        check("ldi_back_f0", f0());
        ir = 32'h0890_0002; do_instr("ldi_b", 1, 1'b0);
        set_ir(5'd2);  do_instr("st", 2, 1'b0);
        set_ir(5'd19); do_instr("br_nt", 19, 1'b0);
        set_ir(5'd19); do_instr("br_t", 19, 1'b1);
        set_ir(5'd15); do_instr("mul", 15, 1'b0);
        set_ir(5'd30); do_instr("op30", 30, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 31);
            if (op == 27) op = 26;
            set_ir(op[4:0]);
            do_instr($sformatf("rnd%0d_op%0d", n, op), op, 1'($urandom_range(0, 1)));
        end

        // clr arriving mid-instruction (ld T5)
        set_ir(5'd0); con_ff = 1'b0;
        check("ldclr_f0", f0()); step();
        check("ldclr_f1", f1()); step();
        check("ldclr_f2", f2()); step();
        check("ldclr_t3", b(RUN) | b(GRB) | b(BAOUT) | b(YIN)); step();
        check("ldclr_t4", b(RUN) | b(COUT) | b(ZLIN)); step();
        check("ldclr_t5", b(RUN) | b(ZLOUT) | b(MARIN));
        reset_pulse("ldclr");

        // halt opcode
        set_ir(5'd27);
        check("halt_f0", f0()); step();
        check("halt_f1", f1()); step();
        check("halt_f2", f2()); step();
        stop = 1'b1;
        hold_halt("halt_op");
        stop = 1'b0;

        // stop request sampled in FETCH0
        set_ir(5'd3);
        stop = 1'b1;
        check("stop_f0", f0()); step();
        stop = 1'b0;
        hold_halt("halt_stop");

        set_ir(5'd17); do_instr("neg_after", 17, 1'b0);
        check("final_f0", f0());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
